vga_sync_rx: RTL and testbench
==============================

VGA_SYNC_RX -- requirements
Module: vga_sync_rx

Interface
REQ-001 SHALL have parameter HSYNC_ACT_LOW, default 1, meaning the hsync active level is low.
REQ-002 SHALL have parameter VSYNC_ACT_LOW, default 1, meaning the vsync active level is low.
REQ-003 SHALL have parameter LOCK_FRAMES, default 2, meaning consecutive matching frames required to lock (range 1..15).
REQ-004 SHALL have port CLK, input, 1 bit, the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port RST_N, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have ports hsync_in and vsync_in, input, 1 bit each, asynchronous sync pins.
REQ-007 SHALL have ports red_in, green_in and blue_in, input, 1 bit each, asynchronous colour pins.
REQ-008 SHALL have port h_total, output, 12 bits, CLK cycles per line from the last complete line.
REQ-009 SHALL have port h_pulse, output, 12 bits, hsync active width in CLK cycles.
REQ-010 SHALL have port v_total, output, 11 bits, lines per frame from the last complete frame.
REQ-011 SHALL have port v_pulse, output, 11 bits, vsync active width in lines.
REQ-012 SHALL have port pixel_x, output, 12 bits, CLK cycles since the current line start.
REQ-013 SHALL have port pixel_y, output, 11 bits, lines since the current frame start.
REQ-014 SHALL have port frame_stb, output, 1 bit, one-cycle pulse at each detected frame start.
REQ-015 SHALL have port locked, output, 1 bit, high while timing is stable.
REQ-016 SHALL have port lit_count, output, 20 bits, count of lit samples in the last frame.

Function
REQ-017 SHALL pass every input pin through a 2-FF synchronizer, then a 1-FF edge detector, giving a fixed 3-cycle latency from pin edge to internal event.
REQ-018 SHALL treat the inactive-to-active transition of hsync as line start (LS), and that of vsync as frame start (FS).
REQ-019 SHALL on LS latch h_total = hcnt+1, clear hcnt to 0, and increment vcnt; hcnt SHALL otherwise increment each cycle, saturating at 4095.
REQ-020 SHALL on the hsync active-to-inactive edge latch h_pulse = hcnt+1.
REQ-021 SHALL on FS latch v_total = vcnt and clear vcnt to 0, and on vsync deassertion latch v_pulse = vcnt.
REQ-022 SHALL, when LS and FS occur in the same cycle, give FS priority: vcnt = 0, hcnt = 0, and h_total latched.
REQ-023 SHALL drive pixel_x = hcnt and pixel_y = vcnt combinationally from the counters.
REQ-024 SHALL assert frame_stb for exactly one cycle, the cycle after FS is detected.
REQ-025 SHALL implement FSM SEARCH -> MEASURE -> LOCKED, one state transition per FS.
REQ-026 SEARCH SHALL move to MEASURE on the first FS, snapshotting h_total and v_total as the reference.
REQ-027 MEASURE SHALL increment a match counter on each FS where h_total and v_total equal the reference.
REQ-028 MEASURE SHALL reload the reference and clear the match counter on a mismatch.
REQ-029 MEASURE SHALL move to LOCKED when the match count reaches LOCK_FRAMES.
REQ-030 LOCKED SHALL return to SEARCH on any FS whose values differ from the reference.
REQ-031 Any state SHALL return to SEARCH on hcnt saturation (no LS for 4096 cycles).
REQ-032 locked SHALL equal (state == LOCKED) and be registered.
REQ-033 Counter vcnt SHALL saturate at 2047 and SHALL NOT wrap.

Reset
REQ-034 RST_N low SHALL asynchronously clear all synchronizers to the inactive sync level and all counters and outputs to 0, set the FSM to SEARCH, and set locked = 0 and frame_stb = 0.
REQ-035 Reset mid-frame SHALL discard partial measurements; the first FS after release only enters MEASURE.

Configuration
REQ-036 With macro VGA_SYNC_RX_COLOR_EN defined, SHALL count cycles where any synchronized colour bit is high, saturating at 2^20-1, latch the count to lit_count on FS, and clear the internal count on FS.
REQ-037 Without VGA_SYNC_RX_COLOR_EN, colour synchronizers and counter SHALL be omitted and lit_count SHALL be tied to 0.

Structure
REQ-038 Package vga_rx_pkg SHALL hold the FSM state enum and the width constants HW=12, VW=11 and LW=20.
REQ-039 Sub-module sync_edge (2-FF sync plus rise/fall detect, parameterised inactive level) SHALL be instantiated per sync and colour pin.

Verification
REQ-040 Generator 400-clk lines (48-clk hsync), 525 lines/frame (2-line vsync) -> h_total=400, h_pulse=48, v_total=525, v_pulse=2; locked rises on the 3rd FS.
REQ-041 Locked stream, then one frame with 524 lines -> locked falls on that FS; re-locks 2 matching frames later.
REQ-042 hsync held inactive 5000 cycles -> SEARCH, locked=0 by cycle 4096+3.
REQ-043 hsync and vsync asserted same cycle -> pixel_y=0, pixel_x=0 four cycles later, one frame_stb.
REQ-044 Reset pulse mid-frame -> all outputs 0 immediately; locked only after LOCK_FRAMES+1 further FS.
REQ-045 With VGA_SYNC_RX_COLOR_EN, red high for 100 cycles per line -> lit_count=52500 after next FS; without the macro -> 0.

Source files
------------

// File: rtl/vga_rx_pkg.sv
// Shared widths and FSM state type for the VGA sync receiver.
package vga_rx_pkg;

  localparam int unsigned HW = 12;  // horizontal counter width (CLK cycles)
  localparam int unsigned VW = 11;  // vertical counter width (lines)
  localparam int unsigned LW = 20;  // lit-sample counter width

  typedef enum logic [1:0] {
    StSearch,
    StMeasure,
    StLocked
  } rx_state_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by one edge-detect flop. Reset loads the
// inactive level so releasing reset never produces a spurious edge.
module sync_edge #(
  parameter logic INACTIVE = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic act_o,
  output logic deact_o
);

  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;

  // Shift the pin through the synchronizer and the edge-detect stage.
  always_comb begin
    s1_d = d_i;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  // Synchronizer and edge-detect registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= INACTIVE;
      s2_q <= INACTIVE;
      s3_q <= INACTIVE;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign level_o = s2_q;
  assign act_o   = (s2_q != INACTIVE) && (s3_q == INACTIVE);
  assign deact_o = (s2_q == INACTIVE) && (s3_q != INACTIVE);

endmodule

// File: rtl/vga_sync_rx.sv
// VGA sync receiver: measures line/frame timing from hsync/vsync, tracks the
// current pixel position and locks once timing repeats. Define
// VGA_SYNC_RX_COLOR_EN to add the per-frame lit-sample counter.
module vga_sync_rx
  import vga_rx_pkg::*;
#(
  parameter bit          HSYNC_ACT_LOW = 1'b1,
  parameter bit          VSYNC_ACT_LOW = 1'b1,
  parameter int unsigned LOCK_FRAMES   = 2
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          hsync_in,
  input  logic          vsync_in,
  input  logic          red_in,
  input  logic          green_in,
  input  logic          blue_in,
  output logic [HW-1:0] h_total,
  output logic [HW-1:0] h_pulse,
  output logic [VW-1:0] v_total,
  output logic [VW-1:0] v_pulse,
  output logic [HW-1:0] pixel_x,
  output logic [VW-1:0] pixel_y,
  output logic          frame_stb,
  output logic          locked,
  output logic [LW-1:0] lit_count
);

  localparam logic [HW-1:0] HMax  = '1;
  localparam logic [VW-1:0] VMax  = '1;
  localparam logic [3:0]    LockN = 4'(LOCK_FRAMES);

  logic h_lvl, h_act, h_deact;
  logic v_lvl, v_act, v_deact;
  logic unused_sig;

  // An active-low sync idles high, so the inactive level equals the flag.
  sync_edge #(.INACTIVE(HSYNC_ACT_LOW)) u_hsync (
    .clk_i(CLK), .rst_ni(RST_N), .d_i(hsync_in),
    .level_o(h_lvl), .act_o(h_act), .deact_o(h_deact)
  );

  sync_edge #(.INACTIVE(VSYNC_ACT_LOW)) u_vsync (
    .clk_i(CLK), .rst_ni(RST_N), .d_i(vsync_in),
    .level_o(v_lvl), .act_o(v_act), .deact_o(v_deact)
  );

  logic [HW-1:0] hcnt_q, hcnt_d, h_total_q, h_total_d, h_pulse_q, h_pulse_d;
  logic [VW-1:0] vcnt_q, vcnt_d, v_total_q, v_total_d, v_pulse_q, v_pulse_d;
  logic [HW-1:0] hcnt_inc;
  logic          frame_stb_q, frame_stb_d;

  assign hcnt_inc = (hcnt_q == HMax) ? HMax : hcnt_q + 1'b1;

  // Line/frame counters and timing latches; frame start wins over line start.
  always_comb begin
    hcnt_d      = hcnt_inc;
    vcnt_d      = vcnt_q;
    h_total_d   = h_total_q;
    h_pulse_d   = h_pulse_q;
    v_total_d   = v_total_q;
    v_pulse_d   = v_pulse_q;
    frame_stb_d = v_act;
    if (h_act) begin
      h_total_d = hcnt_inc;
      hcnt_d    = '0;
      if (vcnt_q != VMax) vcnt_d = vcnt_q + 1'b1;
    end
    if (h_deact) h_pulse_d = hcnt_inc;
    if (v_act) begin
      v_total_d = vcnt_q;
      vcnt_d    = '0;
    end
    if (v_deact) v_pulse_d = vcnt_q;
  end

  rx_state_e     state_q, state_d;
  logic [HW-1:0] ref_h_q, ref_h_d;
  logic [VW-1:0] ref_v_q, ref_v_d;
  logic [3:0]    match_q, match_d;
  logic [3:0]    match_inc;
  logic          same;
  logic          locked_q, locked_d;

  // Compare the values being latched at this frame start, not the stale ones.
  assign same      = (h_total_d == ref_h_q) && (v_total_d == ref_v_q);
  assign match_inc = match_q + 4'd1;

  // Lock FSM: one transition per frame start; a stalled line counter aborts.
  always_comb begin
    state_d = state_q;
    ref_h_d = ref_h_q;
    ref_v_d = ref_v_q;
    match_d = match_q;
    if (hcnt_q == HMax) begin
      state_d = StSearch;
      match_d = '0;
    end else if (v_act) begin
      unique case (state_q)
        StSearch: begin
          state_d = StMeasure;
          ref_h_d = h_total_d;
          ref_v_d = v_total_d;
          match_d = '0;
        end
        StMeasure: begin
          if (same) begin
            match_d = match_inc;
            if (match_inc >= LockN) state_d = StLocked;
          end else begin
            ref_h_d = h_total_d;
            ref_v_d = v_total_d;
            match_d = '0;
          end
        end
        StLocked: if (!same) state_d = StSearch;
        default:  state_d = StSearch;
      endcase
    end
    locked_d = (state_d == StLocked);
  end

  // Timing, counter and FSM state registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      h_total_q   <= '0;
      h_pulse_q   <= '0;
      v_total_q   <= '0;
      v_pulse_q   <= '0;
      frame_stb_q <= 1'b0;
      state_q     <= StSearch;
      ref_h_q     <= '0;
      ref_v_q     <= '0;
      match_q     <= '0;
      locked_q    <= 1'b0;
    end else begin
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      h_total_q   <= h_total_d;
      h_pulse_q   <= h_pulse_d;
      v_total_q   <= v_total_d;
      v_pulse_q   <= v_pulse_d;
      frame_stb_q <= frame_stb_d;
      state_q     <= state_d;
      ref_h_q     <= ref_h_d;
      ref_v_q     <= ref_v_d;
      match_q     <= match_d;
      locked_q    <= locked_d;
    end
  end

  assign h_total   = h_total_q;
  assign h_pulse   = h_pulse_q;
  assign v_total   = v_total_q;
  assign v_pulse   = v_pulse_q;
  assign pixel_x   = hcnt_q;
  assign pixel_y   = vcnt_q;
  assign frame_stb = frame_stb_q;
  assign locked    = locked_q;

`ifdef VGA_SYNC_RX_COLOR_EN
  logic r_lvl, r_act, r_deact;
  logic g_lvl, g_act, g_deact;
  logic b_lvl, b_act, b_deact;
  logic [LW-1:0] lit_cnt_q, lit_cnt_d, lit_count_q, lit_count_d;

  sync_edge #(.INACTIVE(1'b0)) u_red (
    .clk_i(CLK), .rst_ni(RST_N), .d_i(red_in),
    .level_o(r_lvl), .act_o(r_act), .deact_o(r_deact)
  );
  sync_edge #(.INACTIVE(1'b0)) u_green (
    .clk_i(CLK), .rst_ni(RST_N), .d_i(green_in),
    .level_o(g_lvl), .act_o(g_act), .deact_o(g_deact)
  );
  sync_edge #(.INACTIVE(1'b0)) u_blue (
    .clk_i(CLK), .rst_ni(RST_N), .d_i(blue_in),
    .level_o(b_lvl), .act_o(b_act), .deact_o(b_deact)
  );

  // Count lit samples per frame; publish and restart at each frame start.
  always_comb begin
    lit_cnt_d   = lit_cnt_q;
    lit_count_d = lit_count_q;
    if (v_act) begin
      lit_count_d = lit_cnt_q;
      lit_cnt_d   = '0;
    end else if ((r_lvl || g_lvl || b_lvl) && (lit_cnt_q != '1)) begin
      lit_cnt_d = lit_cnt_q + 1'b1;
    end
  end

  // Lit counter registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lit_cnt_q   <= '0;
      lit_count_q <= '0;
    end else begin
      lit_cnt_q   <= lit_cnt_d;
      lit_count_q <= lit_count_d;
    end
  end

  assign lit_count  = lit_count_q;
  assign unused_sig = ^{h_lvl, v_lvl, r_act, r_deact, g_act, g_deact, b_act, b_deact};
`else
  assign lit_count  = '0;
  assign unused_sig = ^{h_lvl, v_lvl, red_in, green_in, blue_in};
`endif

endmodule

// File: tb/tb_vga_sync_rx.sv
// Directed bench for vga_sync_rx using a reduced video timing:
// 64-clk lines with 8-clk hsync, 20 lines/frame with 2-line vsync.
module tb_vga_sync_rx;

  localparam int LineLen = 64;
  localparam int HsW     = 8;
  localparam int VOff    = 32;  // vsync edges sit mid-line, away from hsync

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        hsync_in = 1'b1, vsync_in = 1'b1;
  logic        red_in = 1'b0, green_in = 1'b0, blue_in = 1'b0;
  logic [11:0] h_total, h_pulse, pixel_x;
  logic [10:0] v_total, v_pulse, pixel_y;
  logic        frame_stb, locked;
  logic [19:0] lit_count;

  int total = 0;
  int bad = 0;
  int stb_cnt = 0;
  bit red_en = 1'b0;

  vga_sync_rx #(
    .HSYNC_ACT_LOW(1'b1),
    .VSYNC_ACT_LOW(1'b1),
    .LOCK_FRAMES(2)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .h_total(h_total), .h_pulse(h_pulse), .v_total(v_total), .v_pulse(v_pulse),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .frame_stb(frame_stb),
    .locked(locked), .lit_count(lit_count)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (frame_stb) stb_cnt <= stb_cnt + 1;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Run the first 'stop' lines of an nl-line frame. 'first' suppresses the
  // vsync tail from a previous frame that never happened.
  task automatic run_lines(input int nl, input bit first, input int stop);
    bit vs_a;
    for (int l = 0; l < stop; l++) begin
      for (int c = 0; c < LineLen; c++) begin
        vs_a = (l == nl - 1 && c >= VOff) || (!first && (l == 0 || (l == 1 && c < VOff)));
        hsync_in = !(c < HsW);
        vsync_in = !vs_a;
        red_in   = red_en && c >= 40 && c < 50;
        tick();
      end
    end
  endtask

  task automatic apply_reset();
    RST_N = 1'b0;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    red_in = 1'b0;
    repeat (3) tick();
    RST_N = 1'b1;
    repeat (2) tick();
  endtask

  task automatic check_zero(input string tag);
    total++;
    if ({h_total, h_pulse, v_total, v_pulse, pixel_x, pixel_y} !== '0) begin
      bad++;
      $display("FAIL %s timing: got %h/%h/%h/%h/%h/%h want all 0", tag,
               h_total, h_pulse, v_total, v_pulse, pixel_x, pixel_y);
    end
    total++;
    if ({frame_stb, locked, lit_count} !== '0) begin
      bad++;
      $display("FAIL %s flags: got stb=%b locked=%b lit=%0d want 0", tag,
               frame_stb, locked, lit_count);
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (3) tick();
    check_zero("reset");
    RST_N = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_simultaneous();
    int stb0;
    apply_reset();
    repeat (10) tick();
    stb0 = stb_cnt;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    repeat (3) tick();
    total++;
    if (pixel_x !== 12'd0 || pixel_y !== 11'd0) begin
      bad++;
      $display("FAIL simul_pos: got x=%0d y=%0d want 0/0", pixel_x, pixel_y);
    end
    total++;
    if (frame_stb !== 1'b1) begin
      bad++;
      $display("FAIL simul_stb: got %b want 1", frame_stb);
    end
    tick();
    total++;
    if (frame_stb !== 1'b0 || pixel_x !== 12'd1 || pixel_y !== 11'd0) begin
      bad++;
      $display("FAIL simul_next: got stb=%b x=%0d y=%0d want 0/1/0", frame_stb, pixel_x, pixel_y);
    end
    repeat (10) tick();
    total++;
    if (stb_cnt - stb0 !== 1) begin
      bad++;
      $display("FAIL simul_stb_count: got %0d want 1", stb_cnt - stb0);
    end
  endtask

  task automatic test_lock();
    int stb0;
    apply_reset();
    stb0 = stb_cnt;
    run_lines(20, 1'b1, 20);
    total++;
    if (locked !== 1'b0 || h_total !== 12'd64 || v_total !== 11'd20) begin
      bad++;
      $display("FAIL lock_fs1: got locked=%b h_total=%0d v_total=%0d want 0/64/20",
               locked, h_total, v_total);
    end
    run_lines(20, 1'b0, 20);
    total++;
    if (locked !== 1'b0) begin
      bad++;
      $display("FAIL lock_fs2: got locked=%b want 0", locked);
    end
    total++;
    if (h_pulse !== 12'd8 || v_pulse !== 11'd2) begin
      bad++;
      $display("FAIL pulses: got h_pulse=%0d v_pulse=%0d want 8/2", h_pulse, v_pulse);
    end
    run_lines(20, 1'b0, 20);
    total++;
    if (locked !== 1'b1) begin
      bad++;
      $display("FAIL lock_fs3: got locked=%b want 1", locked);
    end
    total++;
    if (stb_cnt - stb0 !== 3) begin
      bad++;
      $display("FAIL lock_stb_count: got %0d want 3", stb_cnt - stb0);
    end
  endtask

  task automatic test_short_frame();
    run_lines(19, 1'b0, 19);
    total++;
    if (locked !== 1'b0 || v_total !== 11'd19) begin
      bad++;
      $display("FAIL short_drop: got locked=%b v_total=%0d want 0/19", locked, v_total);
    end
    run_lines(20, 1'b0, 20);
    run_lines(20, 1'b0, 20);
    total++;
    if (locked !== 1'b0) begin
      bad++;
      $display("FAIL short_relock_early: got locked=%b want 0", locked);
    end
    run_lines(20, 1'b0, 20);
    total++;
    if (locked !== 1'b1 || v_total !== 11'd20) begin
      bad++;
      $display("FAIL short_relock: got locked=%b v_total=%0d want 1/20", locked, v_total);
    end
  endtask

  task automatic test_hsync_hold();
    hsync_in = 1'b1;
    repeat (3800) tick();
    total++;
    if (locked !== 1'b1) begin
      bad++;
      $display("FAIL hold_early: got locked=%b want 1", locked);
    end
    repeat (350) tick();
    total++;
    if (locked !== 1'b0 || pixel_x !== 12'd4095) begin
      bad++;
      $display("FAIL hold_sat: got locked=%b x=%0d want 0/4095", locked, pixel_x);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    repeat (3) run_lines(20, 1'b0, 20);
    run_lines(20, 1'b0, 10);
    RST_N = 1'b0;
    #1;
    check_zero("reset_mid");
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    repeat (3) tick();
    RST_N = 1'b1;
    repeat (2) tick();
    run_lines(20, 1'b1, 20);
    run_lines(20, 1'b0, 20);
    total++;
    if (locked !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_early: got locked=%b want 0", locked);
    end
    run_lines(20, 1'b0, 20);
    total++;
    if (locked !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_relock: got locked=%b want 1", locked);
    end
  endtask

  task automatic test_colour();
    logic [19:0] exp_lit;
`ifdef VGA_SYNC_RX_COLOR_EN
    exp_lit = 20'd200;
`else
    exp_lit = 20'd0;
`endif
    red_en = 1'b1;
    run_lines(20, 1'b0, 20);
    run_lines(20, 1'b0, 20);
    total++;
    if (lit_count !== exp_lit) begin
      bad++;
      $display("FAIL lit_count: got %0d want %0d", lit_count, exp_lit);
    end
    red_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_lock();
    test_short_frame();
    test_hsync_hold();
    test_reset_mid();
    test_colour();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
